// File: rtl/cmd_dispatcher.sv
// cmd_dispatcher: decodes single-byte UART commands and sequences the test,
// sampler and sample-reader units over a level activate/done handshake.
// Only one unit is active at a time. Each phase has a timeout. An abort
// command is supported, and 0x23 runs the sampler and then the reader.
module cmd_dispatcher #(
  parameter int TIMEOUT_CYCLES = 50_000_000,
  parameter int CNT_W          = $clog2(TIMEOUT_CYCLES)
) (
  input  logic       clk_50mhz,
  input  logic       reset,
  input  logic [7:0] rx_data,
  input  logic       rx_ready,
  output logic       test_activate,
  input  logic       test_done,
  output logic       sampler_activate,
  input  logic       sampler_done,
  output logic       reader_activate,
  input  logic       reader_done,
  output logic [7:0] state,
  output logic       busy,
  output logic [7:0] result,
  output logic       dropped
);

  localparam logic [7:0] CMD_ABORT  = 8'h00;
  localparam logic [7:0] CMD_TEST   = 8'h11;
  localparam logic [7:0] CMD_SAMPLE = 8'h21;
  localparam logic [7:0] CMD_READ   = 8'h22;
  localparam logic [7:0] CMD_CHAIN  = 8'h23;

  localparam logic [7:0] RES_NONE    = 8'h00;
  localparam logic [7:0] RES_OK      = 8'hA0;
  localparam logic [7:0] RES_UNKNOWN = 8'hE1;
  localparam logic [7:0] RES_TIMEOUT = 8'hE2;
  localparam logic [7:0] RES_ABORTED = 8'hE3;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} fsm_t;

  fsm_t             fsm_q, fsm_d;
  logic [7:0]       phase_q, phase_d;
  logic             chain_q, chain_d;
  logic             abort_q, abort_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       result_d;
  logic             dropped_d;
  logic             phase_done;
  logic             rx_abort;
  logic             rx_other;
  logic             abort_taken;

  assign rx_abort    = rx_ready && (rx_data == CMD_ABORT);
  assign rx_other    = rx_ready && (rx_data != CMD_ABORT);
  assign abort_taken = abort_q || rx_abort;

  // Select the done line that belongs to the current phase
  always_comb begin
    // NOTE: every always_comb output gets a default first so that no path
    // leaves it unassigned, which would otherwise infer a latch.
    phase_done = 1'b0;
    case (phase_q)
      CMD_TEST:   phase_done = test_done;
      CMD_SAMPLE: phase_done = sampler_done;
      CMD_READ:   phase_done = reader_done;
      default:    phase_done = 1'b0;
    endcase
  end

  // Next-state logic: phase sequencing, timeout, abort and result codes
  always_comb begin
    fsm_d     = fsm_q;
    phase_d   = phase_q;
    chain_d   = chain_q;
    abort_d   = abort_q;
    result_d  = result;
    dropped_d = 1'b0;
    // Saturating phase counter; it is cleared on every RUN or DRAIN entry.
    cnt_d     = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;

    case (fsm_q)
      IDLE: begin
        cnt_d   = '0;
        abort_d = 1'b0;
        chain_d = 1'b0;
        if (rx_ready) begin
          case (rx_data)
            CMD_TEST, CMD_SAMPLE, CMD_READ: begin
              fsm_d   = RUN;
              phase_d = rx_data;
            end
            CMD_CHAIN: begin
              fsm_d   = RUN;
              phase_d = CMD_SAMPLE;
              chain_d = 1'b1;
            end
            CMD_ABORT: ;
            default: result_d = RES_UNKNOWN;
          endcase
        end
      end

      RUN: begin
        dropped_d = rx_other;
        // An abort has priority over done, and done has priority over timeout.
        if (rx_abort) begin
          fsm_d   = DRAIN;
          abort_d = 1'b1;
          cnt_d   = '0;
        end else if (phase_done) begin
          fsm_d = DRAIN;
          cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
          fsm_d    = IDLE;
          result_d = RES_TIMEOUT;
        end
      end

      DRAIN: begin
        dropped_d = rx_other;
        if (rx_abort) abort_d = 1'b1;
        if (!phase_done) begin
          if (chain_q && (phase_q == CMD_SAMPLE) && !abort_taken) begin
            fsm_d   = RUN;
            phase_d = CMD_READ;
            cnt_d   = '0;
          end else begin
            fsm_d    = IDLE;
            result_d = abort_taken ? RES_ABORTED : RES_OK;
          end
        end else if (cnt_q == CNT_LAST) begin
          fsm_d    = IDLE;
          result_d = RES_TIMEOUT;
        end
      end

      default: fsm_d = IDLE;
    endcase
  end

  // State and registered outputs; the activates are decoded from the next phase
  always_ff @(posedge clk_50mhz) begin
    // NOTE: sequential state uses non-blocking assignments so that every
    // flop samples the pre-edge values, independent of statement order.
    if (reset) begin
      fsm_q            <= IDLE;
      phase_q          <= 8'h00;
      chain_q          <= 1'b0;
      abort_q          <= 1'b0;
      cnt_q            <= '0;
      test_activate    <= 1'b0;
      sampler_activate <= 1'b0;
      reader_activate  <= 1'b0;
      state            <= 8'h00;
      busy             <= 1'b0;
      result           <= RES_NONE;
      dropped          <= 1'b0;
    end else begin
      fsm_q            <= fsm_d;
      phase_q          <= phase_d;
      chain_q          <= chain_d;
      abort_q          <= abort_d;
      cnt_q            <= cnt_d;
      test_activate    <= (fsm_d == RUN) && (phase_d == CMD_TEST);
      sampler_activate <= (fsm_d == RUN) && (phase_d == CMD_SAMPLE);
      reader_activate  <= (fsm_d == RUN) && (phase_d == CMD_READ);
      state            <= (fsm_d == IDLE) ? 8'h00 : phase_d;
      busy             <= (fsm_d != IDLE);
      result           <= result_d;
      dropped          <= dropped_d;
    end
  end

endmodule

// File: tb/tb_cmd_dispatcher.sv
// Directed testbench for cmd_dispatcher with TIMEOUT_CYCLES = 16.
// Inputs change 1 time unit after the rising edge, and outputs are sampled
// at the same point. Every expected value below is worked out by hand.
module tb_cmd_dispatcher;

  localparam int TO = 16;

  logic       clk_50mhz = 1'b0;
  logic       reset     = 1'b1;
  logic [7:0] rx_data   = 8'h00;
  logic       rx_ready  = 1'b0;
  logic       test_done = 1'b0;
  logic       sampler_done = 1'b0;
  logic       reader_done  = 1'b0;
  logic       test_activate, sampler_activate, reader_activate;
  logic [7:0] state, result;
  logic       busy, dropped;
  logic [2:0] acts;

  int checks = 0;
  int errors = 0;

  assign acts = {test_activate, sampler_activate, reader_activate};

  cmd_dispatcher #(.TIMEOUT_CYCLES(TO)) dut (
    .clk_50mhz        (clk_50mhz),
    .reset            (reset),
    .rx_data          (rx_data),
    .rx_ready         (rx_ready),
    .test_activate    (test_activate),
    .test_done        (test_done),
    .sampler_activate (sampler_activate),
    .sampler_done     (sampler_done),
    .reader_activate  (reader_activate),
    .reader_done      (reader_done),
    .state            (state),
    .busy             (busy),
    .result           (result),
    .dropped          (dropped)
  );

  // 50 MHz clock
  always #10 clk_50mhz = ~clk_50mhz;

  task automatic tick();
    @(posedge clk_50mhz);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    rx_data  = b;
    rx_ready = 1'b1;
    tick();
    rx_ready = 1'b0;
    rx_data  = 8'h00;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    checks++; if (acts !== 3'b000) begin errors++; $display("FAIL reset_acts: got %b expected 000", acts); end
    checks++; if (state !== 8'h00) begin errors++; $display("FAIL reset_state: got %h expected 00", state); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (result !== 8'h00) begin errors++; $display("FAIL reset_result: got %h expected 00", result); end
    checks++; if (dropped !== 1'b0) begin errors++; $display("FAIL reset_dropped: got %b expected 0", dropped); end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_single();
    send(8'h11);
    checks++; if (acts !== 3'b100) begin errors++; $display("FAIL single_act_on: got %b expected 100", acts); end
    checks++; if (state !== 8'h11) begin errors++; $display("FAIL single_state_run: got %h expected 11", state); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy: got %b expected 1", busy); end
    repeat (4) tick();
    test_done = 1'b1;
    checks++; if (acts !== 3'b100) begin errors++; $display("FAIL single_act_held: got %b expected 100", acts); end
    tick();
    checks++; if (acts !== 3'b000) begin errors++; $display("FAIL single_act_off: got %b expected 000", acts); end
    checks++; if (state !== 8'h11) begin errors++; $display("FAIL single_state_drain: got %h expected 11", state); end
    test_done = 1'b0;
    tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_idle_busy: got %b expected 0", busy); end
    checks++; if (state !== 8'h00) begin errors++; $display("FAIL single_idle_state: got %h expected 00", state); end
    checks++; if (result !== 8'hA0) begin errors++; $display("FAIL single_result: got %h expected a0", result); end
  endtask

  task automatic test_chain();
    send(8'h23);
    checks++; if (acts !== 3'b010) begin errors++; $display("FAIL chain_sampler_on: got %b expected 010", acts); end
    checks++; if (state !== 8'h21) begin errors++; $display("FAIL chain_state_21: got %h expected 21", state); end
    repeat (2) tick();
    sampler_done = 1'b1;
    tick();
    checks++; if (acts !== 3'b000) begin errors++; $display("FAIL chain_gap: got %b expected 000", acts); end
    sampler_done = 1'b0;
    tick();
    checks++; if (acts !== 3'b001) begin errors++; $display("FAIL chain_reader_on: got %b expected 001", acts); end
    checks++; if (state !== 8'h22) begin errors++; $display("FAIL chain_state_22: got %h expected 22", state); end
    repeat (2) tick();
    reader_done = 1'b1;
    tick();
    checks++; if (acts !== 3'b000) begin errors++; $display("FAIL chain_reader_off: got %b expected 000", acts); end
    reader_done = 1'b0;
    tick();
    checks++; if (state !== 8'h00) begin errors++; $display("FAIL chain_state_idle: got %h expected 00", state); end
    checks++; if (result !== 8'hA0) begin errors++; $display("FAIL chain_result: got %h expected a0", result); end
  endtask

  task automatic test_timeout();
    int bad;
    bad = 0;
    send(8'h21);
    for (int i = 0; i < TO - 1; i++) begin
      if (acts !== 3'b010) bad++;
      tick();
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL timeout_held: got %0d low cycles expected 0", bad); end
    checks++; if (acts !== 3'b010) begin errors++; $display("FAIL timeout_last_cycle: got %b expected 010", acts); end
    checks++; if (result !== 8'hA0) begin errors++; $display("FAIL timeout_sticky: got %h expected a0", result); end
    tick();
    checks++; if (acts !== 3'b000) begin errors++; $display("FAIL timeout_act_off: got %b expected 000", acts); end
    checks++; if (result !== 8'hE2) begin errors++; $display("FAIL timeout_result: got %h expected e2", result); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL timeout_busy: got %b expected 0", busy); end
  endtask

  task automatic test_done_beats_timeout();
    send(8'h21);
    repeat (TO - 1) tick();
    sampler_done = 1'b1;
    tick();
    checks++; if (acts !== 3'b000) begin errors++; $display("FAIL done_to_act: got %b expected 000", acts); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL done_to_busy: got %b expected 1", busy); end
    checks++; if (result !== 8'hE2) begin errors++; $display("FAIL done_to_sticky: got %h expected e2", result); end
    sampler_done = 1'b0;
    tick();
    checks++; if (result !== 8'hA0) begin errors++; $display("FAIL done_to_result: got %h expected a0", result); end
  endtask

  task automatic test_abort();
    send(8'h23);
    tick();
    send(8'h00);
    checks++; if (acts !== 3'b000) begin errors++; $display("FAIL abort_act_off: got %b expected 000", acts); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL abort_busy: got %b expected 1", busy); end
    checks++; if (dropped !== 1'b0) begin errors++; $display("FAIL abort_dropped: got %b expected 0", dropped); end
    tick();
    checks++; if (result !== 8'hE3) begin errors++; $display("FAIL abort_result: got %h expected e3", result); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_idle: got %b expected 0", busy); end
    repeat (3) tick();
    checks++; if (acts !== 3'b000) begin errors++; $display("FAIL abort_no_reader: got %b expected 000", acts); end
  endtask

  task automatic test_abort_with_done();
    send(8'h11);
    tick();
    test_done = 1'b1;
    send(8'h00);
    checks++; if (acts !== 3'b000) begin errors++; $display("FAIL abdone_act: got %b expected 000", acts); end
    test_done = 1'b0;
    tick();
    checks++; if (result !== 8'hE3) begin errors++; $display("FAIL abdone_result: got %h expected e3", result); end
  endtask

  task automatic test_abort_in_drain();
    send(8'h23);
    tick();
    sampler_done = 1'b1;
    tick();
    send(8'h00);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL abdrain_busy: got %b expected 1", busy); end
    sampler_done = 1'b0;
    tick();
    checks++; if (acts !== 3'b000) begin errors++; $display("FAIL abdrain_no_reader: got %b expected 000", acts); end
    checks++; if (result !== 8'hE3) begin errors++; $display("FAIL abdrain_result: got %h expected e3", result); end
  endtask

  task automatic test_unknown_and_drop();
    send(8'h55);
    checks++; if (result !== 8'hE1) begin errors++; $display("FAIL unknown_result: got %h expected e1", result); end
    checks++; if ({acts, busy, dropped} !== 5'b00000) begin errors++; $display("FAIL unknown_quiet: got %b expected 00000", {acts, busy, dropped}); end
    send(8'h00);
    checks++; if ({result, busy, dropped} !== {8'hE1, 2'b00}) begin errors++; $display("FAIL idle_abort: got %h expected e1 0 0", {result, busy, dropped}); end
    send(8'h11);
    send(8'h22);
    checks++; if (dropped !== 1'b1) begin errors++; $display("FAIL drop_pulse: got %b expected 1", dropped); end
    checks++; if ({acts, state} !== {3'b100, 8'h11}) begin errors++; $display("FAIL drop_phase: got %h expected 411", {acts, state}); end
    tick();
    checks++; if (dropped !== 1'b0) begin errors++; $display("FAIL drop_one_cycle: got %b expected 0", dropped); end
    test_done = 1'b1;
    tick();
    test_done = 1'b0;
    tick();
    checks++; if (result !== 8'hA0) begin errors++; $display("FAIL drop_result: got %h expected a0", result); end
  endtask

  task automatic test_reset_mid_run();
    send(8'h11);
    tick();
    test_done = 1'b1;
    reset     = 1'b1;
    tick();
    checks++; if (acts !== 3'b000) begin errors++; $display("FAIL rstrun_acts: got %b expected 000", acts); end
    checks++; if (state !== 8'h00) begin errors++; $display("FAIL rstrun_state: got %h expected 00", state); end
    checks++; if (result !== 8'h00) begin errors++; $display("FAIL rstrun_result: got %h expected 00", result); end
    checks++; if ({busy, dropped} !== 2'b00) begin errors++; $display("FAIL rstrun_flags: got %b expected 00", {busy, dropped}); end
    reset     = 1'b0;
    test_done = 1'b0;
    tick();
    checks++; if ({acts, busy} !== 4'b0000) begin errors++; $display("FAIL rstrun_stays_idle: got %b expected 0000", {acts, busy}); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_chain();
    test_timeout();
    test_done_beats_timeout();
    test_abort();
    test_abort_with_done();
    test_abort_in_drain();
    test_unknown_and_drop();
    test_reset_mid_run();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
